// File: rtl/rv32i_inst_encoder_pkg.sv
// Shared encodings for the RV32I instruction encoder: request classes, FSM states,
// opcode/funct7 constants and the immediate range helper used when ENCODER_RANGE_CHECK_EN is set.
package rv32i_inst_encoder_pkg;

  typedef enum logic [3:0] {
    CLS_LUI    = 4'd0,
    CLS_AUIPC  = 4'd1,
    CLS_JAL    = 4'd2,
    CLS_JALR   = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_LOAD   = 4'd5,
    CLS_OP_IMM = 4'd6,
    CLS_STORE  = 4'd7,
    CLS_OP     = 4'd8,
    CLS_CSR    = 4'd9
  } req_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // True when v is representable as an nbits-wide two's complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
    logic [31:0] t;
    t = $signed(v) >>> (nbits - 1);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/rv32i_field_pack.sv
// Combinational packer: request class + fields -> 32-bit RV32I word and an illegal flag.
// With ENCODER_RANGE_CHECK_EN defined, out-of-range immediates are also flagged illegal.
module rv32i_field_pack
  import rv32i_inst_encoder_pkg::*;
(
  input  logic [3:0]  i_class,
  input  logic [2:0]  i_funct3,
  input  logic        i_alt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  logic [6:0]  w_f7;
  logic        w_shift;
  logic        w_bad;
  logic [31:0] w_word;

  assign w_f7    = i_alt ? F7_ALT : F7_BASE;
  assign w_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

  always_comb begin
    w_word = '0;
    w_bad  = 1'b0;
    case (i_class)
      CLS_LUI:   w_word = {i_imm[31:12], i_rd, OPC_LUI};
      CLS_AUIPC: w_word = {i_imm[31:12], i_rd, OPC_AUIPC};
      CLS_JAL:   w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
      CLS_JALR:  w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_JALR};
      CLS_BRANCH: begin
        w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], OPC_BRANCH};
        w_bad  = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
      end
      CLS_LOAD: begin
        w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD};
        w_bad  = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
      end
      CLS_OP_IMM: begin
        // Shift-immediates carry funct7 in the upper immediate bits.
        if (w_shift) w_word = {w_f7, i_imm[4:0], i_rs1, i_funct3, i_rd, OPC_OP_IMM};
        else         w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_OP_IMM};
      end
      CLS_STORE: begin
        w_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPC_STORE};
        w_bad  = (i_funct3 >= 3'b011);
      end
      CLS_OP:  w_word = {w_f7, i_rs2, i_rs1, i_funct3, i_rd, OPC_OP};
      CLS_CSR: begin
        w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_SYSTEM};
        w_bad  = (i_funct3[1:0] == 2'b00);
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign o_word = w_word;

`ifdef ENCODER_RANGE_CHECK_EN
  logic w_range_ok;

  always_comb begin
    w_range_ok = 1'b1;
    case (i_class)
      CLS_LUI, CLS_AUIPC:      w_range_ok = (i_imm[11:0] == 12'd0);
      CLS_JAL:                 w_range_ok = fits_signed(i_imm, 21) && !i_imm[0];
      CLS_BRANCH:              w_range_ok = fits_signed(i_imm, 13) && !i_imm[0];
      CLS_OP_IMM:              w_range_ok = w_shift ? (i_imm[31:5] == '0) : fits_signed(i_imm, 12);
      CLS_JALR, CLS_LOAD,
      CLS_STORE:               w_range_ok = fits_signed(i_imm, 12);
      CLS_CSR:                 w_range_ok = (i_imm[31:12] == '0);
      default:                 w_range_ok = 1'b1;
    endcase
  end

  assign o_illegal = w_bad || !w_range_ok;
`else
  assign o_illegal = w_bad;
`endif

endmodule

// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction encoder: packs field bundles into words and streams them into imem
// through an encode register and a backpressure-holding write buffer. Optional: ENCODER_RANGE_CHECK_EN.
module rv32i_inst_encoder
  import rv32i_inst_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_class,
  input  logic [2:0]        req_funct3,
  input  logic              req_alt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       word_count,
  output logic              err
);

  enc_state_e        r_state, w_next;
  logic              r_s1_vld, r_s2_vld;
  logic [31:0]       r_s1_word, r_s2_word;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_count;
  logic              r_err;

  logic [31:0] w_word;
  logic        w_illegal;
  logic [31:0] w_fill;
  logic        w_room, w_write, w_s2_free, w_s1_free, w_accept, w_ovf;

  rv32i_field_pack u_pack (
    .i_class   (req_class),
    .i_funct3  (req_funct3),
    .i_alt     (req_alt),
    .i_rd      (req_rd),
    .i_rs1     (req_rs1),
    .i_rs2     (req_rs2),
    .i_imm     (req_imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // Words already written plus words in flight; only legal words occupy the pipeline.
  assign w_fill    = 32'(r_count) + 32'(r_s1_vld) + 32'(r_s2_vld);
  assign w_room    = w_fill < MAX_WORDS;
  assign w_write   = r_s2_vld && imem_ready && !start;
  assign w_s2_free = !r_s2_vld || w_write;
  assign w_s1_free = !r_s1_vld || w_s2_free;
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    w_ovf     = 1'b0;
    if (start) begin
      w_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: begin
          req_ready = w_s1_free && w_room;
          w_ovf     = req_valid && !w_room;
          if (finish) w_next = ST_DRAIN;
        end
        ST_DRAIN: if (!r_s1_vld && !r_s2_vld) w_next = ST_DONE;
        default: w_next = r_state;
      endcase
    end
    busy = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_word <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_word <= '0;
      r_addr    <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else if (start) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_addr   <= base_addr & ~ADDR_W'(3);
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_write) begin
        r_addr  <= r_addr + ADDR_W'(4);
        r_count <= r_count + 16'd1;
      end
      if (w_s2_free) begin
        r_s2_vld  <= r_s1_vld;
        r_s2_word <= r_s1_word;
      end
      if (w_s1_free) begin
        r_s1_vld  <= w_accept && !w_illegal;
        r_s1_word <= w_word;
      end
      if ((w_accept && w_illegal) || w_ovf) r_err <= 1'b1;
    end
  end

  // A restart cancels the buffered word in the same cycle.
  assign imem_we    = r_s2_vld && !start;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_s2_word;
  assign word_count = r_count;
  assign err        = r_err;

endmodule

// File: doc/rv32i_inst_encoder.md
Name: rv32i_inst_encoder

Overview:
- Inverse of the core's control decoder: accepts decoded instruction fields over a valid/ready stream and packs them into 32-bit RV32I machine words.
- Writes the words sequentially into instruction memory from a programmable base address.
- Used by the debug/boot loader path to build test programs in-system without an external assembler.
- Two-stage pipeline: encode register, then a write buffer that holds under memory backpressure.

Parameters:
- ADDR_W, 32, byte-address width of the imem write port.
- MAX_WORDS, 1024, number of words written after which the block stops accepting and reports overflow.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; latch base_addr, clear counters, enter LOAD
- base_addr  in  ADDR_W  first byte address; bits [1:0] ignored
- finish  in  1  pulse; no more requests, drain pipeline, then DONE
- req_valid  in  1  field bundle valid
- req_ready  out  1  bundle accepted when req_valid && req_ready
- req_class  in  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 OP_IMM, 7 STORE, 8 OP, 9 CSR; others illegal
- req_funct3  in  3  funct3 field
- req_alt  in  1  selects SUB/SRA/SRAI (funct7 = 0100000)
- req_rd, req_rs1, req_rs2  in  5 each  register fields; for CSR immediate forms req_rs1 carries zimm
- req_imm  in  32  immediate; byte offset for B/J; CSR address in imm[11:0] for CSR
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  byte address
- imem_wdata  out  32  encoded word
- imem_ready  in  1  memory accepts the write this cycle
- busy  out  1  state != IDLE && state != DONE
- done  out  1  high in DONE
- word_count  out  16  words written since start
- err  out  1  sticky; illegal request or overflow since start

Behaviour:
- Reset: state IDLE; all outputs 0; imem_addr = 0.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE -> LOAD on start.
  - LOAD -> DRAIN on finish.
  - DRAIN -> DONE when both pipeline stages are empty.
  - DONE -> LOAD on start.
  - start in any state restarts: pipeline flushed, counters and err cleared, no write issued in that cycle.
- req_ready = (state == LOAD) && encode stage empty or advancing && word_count + occupancy < MAX_WORDS.
- Latency: accept in cycle N; imem_we asserted in cycle N+2 at the earliest.
- Write handshake:
  - imem_we, imem_addr and imem_wdata hold stable until imem_ready.
  - On imem_ready, imem_addr advances by 4 and word_count increments.
  - Full throughput is 1 word per cycle.
- Encoding:
  - I-type: [31:20] = imm[11:0].
  - Shift-immediates (OP_IMM, funct3 001/101): [31:25] = {0, alt, 00000}, [24:20] = imm[4:0].
  - S-type: [31:25] = imm[11:5], [11:7] = imm[4:0].
  - B-type: {imm[12], imm[10:5]}, rs2, rs1, f3, {imm[4:1], imm[11]}.
  - U-type: [31:12] = imm[31:12].
  - J-type: imm[20 | 10:1 | 11 | 19:12].
  - R-type: funct7 = {0, alt, 00000}.
  - CSR: [31:20] = imm[11:0], opcode 1110011.
  - Unused fields are zero.
- Illegal class, and funct3 not valid for its class (BRANCH 010/011, LOAD 011/110/111, STORE >= 011, CSR 000/100): word not written, err set, pipeline continues.
- A request arriving while word_count + occupancy reaches MAX_WORDS is never accepted; err is set if req_valid is high in that condition.
- finish and start in the same cycle: start wins.
- rst mid-write drops the pending word.

Optional Feature:
- Macro ENCODER_RANGE_CHECK_EN.
- Defined: immediates are range-checked; a failing request sets err and is dropped.
  - I/S: imm[31:11] all equal.
  - Shift: imm[31:5] == 0.
  - B: 13-bit signed and imm[0] == 0.
  - J: 21-bit signed and imm[0] == 0.
  - U: imm[11:0] == 0.
  - CSR: imm[31:12] == 0.
- Undefined: immediates are silently truncated to their field; only the class/funct3 legality check raises err.

Decomposition:
- Add to the shared Parameters.v: opcode constants (U_LUI, B_TYPE, ... already present), a req_class enum as macros, and funct7 constants.
- Natural combinational sub-module rv32i_field_pack: class + fields -> word + illegal flag. The top level holds the FSM, pipeline registers and counters.

Test Plan:
- start with base 0x100; OP_IMM addi rd1 rs0 imm5 -> imem write 0x00500093 at 0x100; word_count = 1.
- LUI rd2 imm 0x12345000, then BRANCH beq rs1=1 rs2=2 imm -4 -> 0x12345137 @0x100, then 0xFE208EE3 @0x104.
- STORE sw rs2=5 rs1=2 imm 8, OP sub rd3 rs1 1 rs2 2 alt=1, OP_IMM srai rd1 rs1 1 imm 3 alt=1 with imem_ready held low 3 cycles -> 0x00512423, 0x402081B3, 0x4030D093 in order; outputs stable while stalled.
- LOAD funct3 = 111 between two valid addi requests -> err = 1; only 2 words written, at consecutive addresses.
- With ENCODER_RANGE_CHECK_EN, JAL imm 3 -> err = 1 and no write; without the macro -> word written with imm[0] dropped.
- MAX_WORDS = 4: 6 requests -> 4 writes, req_ready low afterwards, err = 1; then finish -> done = 1; then start -> counters cleared, err = 0.
